// File: rtl/display_pkg.sv
// Shared seven-segment types and the hex decode table used by the display scanner.
package display_pkg;

  typedef logic [6:0] seg7_t;

  // Logical (active-high) segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam seg7_t SEG7_OFF = 7'h00;

  localparam seg7_t SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to logical seven-segment pattern decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  always_comb seg_o = SEG7_HEX[nib_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with refresh divider, frame-aligned
// shadow load, per-digit enable, decimal points and leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic                  enable_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_done_o,
  output logic                  load_pend_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam seg7_t               SEG_PIN_OFF = ACTIVE_LOW ? '1 : '0;
  localparam logic [N_DIGITS-1:0] AN_PIN_OFF  = ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                  pend_q, pend_d;
  logic                  fd_q, fd_d;
  seg7_t                 seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  tick, wrap;
  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_en, upper_zero, lit;
  logic [N_DIGITS-1:0]   an_log;
  seg7_t                 seg_dec, seg_log;

  hex_to_seg7 u_dec (
    .nib_i (sel_nib),
    .seg_o (seg_dec)
  );

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    wrap    = enable_i && tick && (idx_q == IDX_LAST);
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (enable_i) begin
      if (tick) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A load arriving in the wrap cycle itself is captured directly and never pends.
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    if (wrap && (pend_q || load_i)) begin
      sh_data_d = data_i;
      sh_dp_d   = dp_i;
    end
    pend_d = !wrap && (pend_q || load_i);
    fd_d   = wrap;
  end

  always_comb begin
    sel_nib    = '0;
    sel_dp     = 1'b0;
    sel_en     = 1'b0;
    upper_zero = 1'b1;
    an_log     = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (IW'(k) == idx_q) begin
        sel_nib   = sh_data_q[4*k +: 4];
        sel_dp    = sh_dp_q[k];
        sel_en    = digit_en_i[k];
        an_log[k] = 1'b1;
      end
      if (IW'(k) >= idx_q && sh_data_q[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end

    lit     = enable_i && sel_en && !(blank_lz_i && (idx_q != '0) && upper_zero);
    seg_log = lit ? seg_dec : SEG7_OFF;
    seg_d   = ACTIVE_LOW ? ~seg_log : seg_log;
    dp_d    = ACTIVE_LOW ? ~(lit && sel_dp) : (lit && sel_dp);
    an_d    = lit ? (ACTIVE_LOW ? ~an_log : an_log) : AN_PIN_OFF;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      pend_q    <= 1'b0;
      fd_q      <= 1'b0;
      seg_q     <= SEG_PIN_OFF;
      dp_q      <= ACTIVE_LOW;
      an_q      <= AN_PIN_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      pend_q    <= pend_d;
      fd_q      <= fd_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_done_o = fd_q;
  assign load_pend_o  = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: active-low and active-high instances
// driven in parallel and compared against a slot-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  localparam logic [6:0] SEGTAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic [15:0]   data_i = '0;
  logic [3:0]    dp_i = '0;
  logic [3:0]    digit_en_i = '0;
  logic          load_i = 1'b0;
  logic          blank_lz_i = 1'b0;
  logic          enable_i = 1'b0;

  logic [6:0]    seg_l, seg_h;
  logic          dp_l, dp_h, fd_l, fd_h, pend_l, pend_h;
  logic [3:0]    an_l, an_h;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;

  // Reference model state: slot position is derived from the count of enabled cycles.
  int unsigned   en_cycles;
  logic [15:0]   m_data;
  logic [3:0]    m_dp;
  bit            m_pend;
  logic [6:0]    e_seg;
  logic          e_dp, e_fd, e_pend;
  logic [3:0]    e_an;

  always #5 clk_i = ~clk_i;

  display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_al (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .dp_i(dp_i),
    .digit_en_i(digit_en_i), .load_i(load_i), .blank_lz_i(blank_lz_i),
    .enable_i(enable_i), .seg_o(seg_l), .dp_o(dp_l), .an_o(an_l),
    .frame_done_o(fd_l), .load_pend_o(pend_l)
  );

  display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .dp_i(dp_i),
    .digit_en_i(digit_en_i), .load_i(load_i), .blank_lz_i(blank_lz_i),
    .enable_i(enable_i), .seg_o(seg_h), .dp_o(dp_h), .an_o(an_h),
    .frame_done_o(fd_h), .load_pend_o(pend_h)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("an_al",   16'(an_l),   16'(4'(~e_an)));
    chk("seg_al",  16'(seg_l),  16'(7'(~e_seg)));
    chk("dp_al",   16'(dp_l),   16'(1'(~e_dp)));
    chk("an_ah",   16'(an_h),   16'(e_an));
    chk("seg_ah",  16'(seg_h),  16'(e_seg));
    chk("dp_ah",   16'(dp_h),   16'(e_dp));
    chk("fdone_al", 16'(fd_l),  16'(e_fd));
    chk("fdone_ah", 16'(fd_h),  16'(e_fd));
    chk("pend_al", 16'(pend_l), 16'(e_pend));
    chk("pend_ah", 16'(pend_h), 16'(e_pend));
  endtask

  task automatic model_reset();
    en_cycles = 0; m_data = '0; m_dp = '0; m_pend = 1'b0;
    e_seg = '0; e_dp = 1'b0; e_an = '0; e_fd = 1'b0; e_pend = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, then compare.
  task automatic step();
    int unsigned idx, cnt;
    bit          wrap, lit;
    idx  = (en_cycles / DIV) % N;
    cnt  = en_cycles % DIV;
    wrap = enable_i && (cnt == DIV - 1) && (idx == N - 1);
    lit  = enable_i && digit_en_i[idx] &&
           !(blank_lz_i && idx != 0 && (m_data >> (4 * idx)) == 16'h0);
    e_seg = lit ? SEGTAB[m_data[4*idx +: 4]] : 7'h00;
    e_dp  = lit && m_dp[idx];
    e_an  = lit ? 4'(1 << idx) : 4'h0;
    @(posedge clk_i);
    if (wrap && (m_pend || load_i)) begin
      m_data = data_i;
      m_dp   = dp_i;
    end
    m_pend = !wrap && (m_pend || load_i);
    if (enable_i) en_cycles++;
    e_fd   = wrap;
    e_pend = m_pend;
    #1;
    check_all();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic load_pulse(input logic [15:0] d);
    data_i = d;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
  endtask

  task automatic wait_phase(input int unsigned ph);
    for (int unsigned k = 0; k < 40 && (en_cycles % (N * DIV)) != ph; k++) step();
    chk("wait_phase", 16'(en_cycles % (N * DIV)), 16'(ph));
  endtask

  // Assert reset between clock edges, check outputs immediately, release mid-cycle.
  task automatic async_reset();
    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    #1;
    check_all();
    #3 rst_n_i = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n_i = 1'b0;
    #2 check_all();
    @(posedge clk_i);
    #1 check_all();
    #3 rst_n_i = 1'b1;

    // Basic scan of 1234 with all digits enabled.
    enable_i   = 1'b1;
    digit_en_i = 4'b1111;
    load_pulse(16'h1234);
    run(40);

    // Mid-frame load: current frame keeps old data, new data from next frame.
    wait_phase(5);
    load_pulse(16'hABCD);
    run(24);

    // Leading-zero blanking.
    blank_lz_i = 1'b1;
    load_pulse(16'h0050);
    run(36);
    load_pulse(16'h0000);
    run(36);
    blank_lz_i = 1'b0;

    // Per-digit enable and decimal points.
    digit_en_i = 4'b1010;
    dp_i       = 4'b0001;
    load_pulse(16'($urandom));
    run(36);
    dp_i = 4'b0110;
    load_pulse(16'($urandom));
    run(36);
    digit_en_i = 4'b1111;
    dp_i       = 4'b0000;

    // Scan pause at index 2, counter 1, then resume.
    wait_phase(9);
    enable_i = 1'b0;
    run(10);
    enable_i = 1'b1;
    run(20);

    // Load requested exactly in the wrap cycle.
    wait_phase(15);
    load_pulse(16'($urandom));
    run(20);

    // Several loads within one frame, data changing afterwards.
    wait_phase(1);
    load_pulse(16'h1111);
    run(3);
    load_pulse(16'h2222);
    data_i = 16'h3C5A;
    run(24);

    // Randomized traffic.
    for (int unsigned i = 0; i < 300; i++) begin
      data_i     = 16'($urandom);
      load_i     = ($urandom_range(0, 7) == 0);
      dp_i       = 4'($urandom);
      blank_lz_i = 1'($urandom);
      enable_i   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) digit_en_i = 4'($urandom);
      step();
    end
    load_i     = 1'b0;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    digit_en_i = 4'b1111;
    dp_i       = 4'b0000;

    // Reset mid-slot with a load pending.
    wait_phase(6);
    load_pulse(16'($urandom));
    async_reset();
    run(20);
    load_pulse(16'h00F0);
    run(36);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
